// File: rtl/decoder_2x4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter and its grant decoder.
package decoder_2x4_rr_arbiter_pkg;

    // Number of requesters sharing the resource.
    localparam int N_REQ = 4;

    // Arbiter FSM states, one-bit encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Decoder implementation variants selectable through DESCRIPTION.
    localparam string DEC_FULLSYS = "FULLSYS";
    localparam string DEC_CASE    = "CASE";
    localparam string DEC_ASSIGN  = "ASSIGN";

    // Shift-based 2-to-4 one-hot decode.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/decoder_2x4_sel.sv
// Wraps the available 2-to-4 decoder variants; DESCRIPTION picks one.
// The output is forced to zero while en is low so an idle arbiter shows no grant.
module decoder_2x4_sel
    import decoder_2x4_rr_arbiter_pkg::*;
#(
    parameter string DESCRIPTION = "CASE"
) (
    input  logic [1:0] idx,
    input  logic       en,
    output logic [3:0] onehot
);

    generate
        if (DESCRIPTION == DEC_FULLSYS) begin : g_fullsys
            // Shift-based decode through the package helper.
            always_comb begin
                onehot = en ? onehot4(idx) : 4'b0000;
            end
        end else if (DESCRIPTION == DEC_ASSIGN) begin : g_assign
            assign onehot = {en &  idx[1] &  idx[0],
                             en &  idx[1] & ~idx[0],
                             en & ~idx[1] &  idx[0],
                             en & ~idx[1] & ~idx[0]};
        end else begin : g_case
            // Table decode; unknown variant names also land here.
            always_comb begin
                onehot = 4'b0000;
                if (en) begin
                    case (idx)
                        2'd0:    onehot = 4'b0001;
                        2'd1:    onehot = 4'b0010;
                        2'd2:    onehot = 4'b0100;
                        2'd3:    onehot = 4'b1000;
                        default: onehot = 4'b0000;
                    endcase
                end else begin
                    onehot = 4'b0000;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/decoder_2x4_rr_arbiter.sv
// Round-robin arbiter sharing one resource among 4 requesters, with a hold
// timeout that pre-empts an owner keeping the grant while others wait.
module decoder_2x4_rr_arbiter
    import decoder_2x4_rr_arbiter_pkg::*;
#(
    parameter int    MAX_HOLD    = 200,
    parameter int    HOLD_W      = 8,
    parameter string DESCRIPTION = "CASE"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [1:0]        gnt_idx,
    output logic              busy,
    output logic              preempt,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam bit              TIMEOUT_ON = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = {HOLD_W{1'b1}};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [1:0]        ptr_r;
    logic [1:0]        ptr_nxt_s;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              preempt_r;
    logic              preempt_nxt_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  gnt_dec_s;
    logic              busy_nxt_s;
    logic              others_s;
    logic [2:0]        pick_s;

    // Round-robin search starting just after the last winner: returns
    // {found, index}. Later loop iterations overwrite earlier ones, so the
    // candidate closest to ptr+1 wins and ptr itself is tried last.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        for (int k = N_REQ; k >= 1; k--) begin
            c = p + 2'(k);
            if (r[c]) begin
                res = {1'b1, c};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration candidate and "someone else is waiting" flag.
    always_comb begin
        pick_s   = rr_pick(req, ptr_r);
        others_s = |(req & ~gnt_r);
    end

    // Next-state logic: grant from IDLE, release or timeout from GRANT.
    always_comb begin
        state_nxt_s   = state_r;
        idx_nxt_s     = idx_r;
        ptr_nxt_s     = ptr_r;
        hold_nxt_s    = hold_r;
        preempt_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en && pick_s[2]) begin
                    state_nxt_s = ST_GRANT;
                    idx_nxt_s   = pick_s[1:0];
                    ptr_nxt_s   = pick_s[1:0];
                    hold_nxt_s  = {HOLD_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                hold_nxt_s = (hold_r == HOLD_SAT) ? hold_r : hold_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                // Release takes precedence so a voluntary drop never pulses preempt.
                if (req[idx_r] == 1'b0) begin
                    state_nxt_s = ST_IDLE;
                end else if (TIMEOUT_ON && (hold_r == HOLD_LAST) && others_s) begin
                    state_nxt_s   = ST_IDLE;
                    preempt_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_GRANT);
    end

    // The grant bus is decoded from the next owner so it can be registered.
    decoder_2x4_sel #(
        .DESCRIPTION (DESCRIPTION)
    ) u_sel (
        .idx    (idx_nxt_s),
        .en     (busy_nxt_s),
        .onehot (gnt_dec_s)
    );

    // FSM, round-robin pointer, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 2'd0;
            ptr_r     <= 2'd3;
            hold_r    <= {HOLD_W{1'b0}};
            preempt_r <= 1'b0;
            gnt_r     <= 4'b0000;
        end else begin
            state_r   <= state_nxt_s;
            idx_r     <= idx_nxt_s;
            ptr_r     <= ptr_nxt_s;
            hold_r    <= hold_nxt_s;
            preempt_r <= preempt_nxt_s;
            gnt_r     <= gnt_dec_s;
        end
    end

    assign gnt      = gnt_r;
    assign gnt_idx  = idx_r;
    assign busy     = (state_r == ST_GRANT);
    assign preempt  = preempt_r;
    assign hold_cnt = hold_r;

endmodule

// File: tb/tb_decoder_2x4_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/pre-emptions with the
// cycle they must appear; a monitor pops and compares as the DUT shows them.
module tb_decoder_2x4_rr_arbiter;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] idx;
    } grant_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       preempt;
    logic [7:0] hold_cnt;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    grant_t gq[$];
    int     pq[$];
    grant_t mon_e;
    int     mon_c;
    logic [3:0] prev_gnt = 4'b0000;

    decoder_2x4_rr_arbiter #(
        .MAX_HOLD    (4),
        .HOLD_W      (8),
        .DESCRIPTION ("CASE")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .busy     (busy),
        .preempt  (preempt),
        .hold_cnt (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_grant(input int c, input logic [3:0] g, input logic [1:0] i);
        grant_t e;
        e.cyc = c;
        e.gnt = g;
        e.idx = i;
        gq.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},     32'(gnt),      32'h0);
        check({tag, "_busy"},    32'(busy),     32'h0);
        check({tag, "_preempt"}, 32'(preempt),  32'h0);
        check({tag, "_hold"},    32'(hold_cnt), 32'h0);
        check({tag, "_idx"},     32'(gnt_idx),  32'h0);
    endtask

    // Monitor: every new non-zero grant and every preempt pulse is matched
    // against the head of its expectation queue.
    always @(negedge clk) begin
        if (gnt !== prev_gnt && gnt !== 4'b0000) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant at cycle %0d: got gnt=%b, expected none", cyc, gnt);
            end else begin
                mon_e = gq.pop_front();
                check("grant_cycle", 32'(cyc),      32'(mon_e.cyc));
                check("grant_gnt",   32'(gnt),      32'(mon_e.gnt));
                check("grant_idx",   32'(gnt_idx),  32'(mon_e.idx));
                check("grant_busy",  32'(busy),     32'h1);
                check("grant_hold",  32'(hold_cnt), 32'h0);
            end
        end
        prev_gnt = gnt;
        if (preempt === 1'b1) begin
            if (pq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_preempt at cycle %0d: got 1, expected 0", cyc);
            end else begin
                mon_c = pq.pop_front();
                check("preempt_cycle", 32'(cyc), 32'(mon_c));
                check("preempt_gnt",   32'(gnt), 32'h0);
            end
        end
    end

    // Stimulus.
    initial begin
        rst = 1'b1;
        en  = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");

        // Rotation 0,1,2,3,0: each owner holds 3 cycles, gap of one cycle.
        for (int k = 0; k < 5; k++) begin
            push_grant(3 + 4 * k, 4'b0001 << (k % 4), 2'(k % 4));
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_cyc(5 + 4 * k);
            if (k < 4) begin
                req[k % 4] = 1'b0;
                wait_cyc(6 + 4 * k);
                check("rotate_gap", 32'(gnt), 32'h0);
                req[k % 4] = 1'b1;
            end else begin
                req = 4'b0000;
            end
        end
        wait_cyc(22);
        check("release_idle", 32'(busy), 32'h0);

        // Timeout: owner 1 holds while 2 waits.
        req = 4'b0110;
        push_grant(23, 4'b0010, 2'd1);
        pq.push_back(27);
        push_grant(28, 4'b0100, 2'd2);
        wait_cyc(26);
        check("hold_before_timeout", 32'(hold_cnt), 32'h3);
        wait_cyc(28);
        req = 4'b0100;

        // Single requester holds past the timeout without pre-emption.
        for (int k = 0; k < 20; k++) begin
            wait_cyc(28 + k);
            check("solo_gnt",     32'(gnt),     32'h4);
            check("solo_preempt", 32'(preempt), 32'h0);
        end
        check("solo_hold", 32'(hold_cnt), 32'd19);

        // Reset in the middle of a grant.
        rst = 1'b1;
        req = 4'b0101;
        wait_cyc(48);
        check_reset("rst_mid");
        push_grant(49, 4'b0001, 2'd0);
        rst = 1'b0;
        wait_cyc(49);
        req = 4'b0000;

        // en=0 blocks new grants.
        wait_cyc(50);
        en  = 1'b0;
        req = 4'b1000;
        for (int k = 1; k <= 3; k++) begin
            wait_cyc(50 + k);
            check("en_block", 32'(gnt), 32'h0);
        end
        en = 1'b1;
        push_grant(54, 4'b1000, 2'd3);
        pq.push_back(58);
        push_grant(59, 4'b0001, 2'd0);

        // Owner 3 pre-empted with everyone requesting: wrap to 0.
        wait_cyc(54);
        req = 4'b1111;
        wait_cyc(59);
        req = 4'b0000;
        wait_cyc(63);
        check("grants_left",   32'(gq.size()), 32'h0);
        check("preempts_left", 32'(pq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
